// File: rtl/sram_responder.sv
// sram_responder: memory-side responder for the request handler's memory port.
// Accepts one read or write per transaction. The access is performed on an
// internal word-addressed RAM after LATENCY extra wait cycles.
//
// State table:
//   IDLE   | waiting for a request; mem_busy low
//   ACCESS | request captured; counting down, commits when counter reaches 0
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset (RAM contents are kept)
//   write_to_mem   write request
//   read_to_mem    read request (dropped if write_to_mem is also high)
//   adr_to_mem     byte address, bits [1:0] ignored
//   data_to_mem    write data
//   sel_to_mem     byte-lane enables
//   data_from_mem  registered read data, held until the next read commits
//   mem_busy       high while a transaction is in flight
//   mem_done       one-cycle pulse on commit
//   adr_err        one-cycle pulse with mem_done for an out-of-range address
module sram_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_to_mem,
  input  logic        read_to_mem,
  input  logic [31:0] adr_to_mem,
  input  logic [31:0] data_to_mem,
  input  logic [3:0]  sel_to_mem,
  output logic [31:0] data_from_mem,
  output logic        mem_busy,
  output logic        mem_done,
  output logic        adr_err
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic [31:2]        cap_adr;
  logic [31:0]        cap_data;
  logic [3:0]         cap_sel;
  logic               cap_we;
  logic [31:0]        ram [DEPTH];

  logic [ADDR_BITS-1:0] word_idx;
  logic [31:2]          hi_bits;
  logic                 out_of_range;
  logic                 commit;
  logic [31:0]          lane_mask;
  logic                 unused_adr_lsbs;

  assign unused_adr_lsbs = ^adr_to_mem[1:0];

  assign word_idx     = cap_adr[ADDR_BITS+1:2];
  // Anything above the word index makes the address out of range.
  assign hi_bits      = cap_adr >> ADDR_BITS;
  assign out_of_range = |hi_bits;
  // Reset wins over a commit on the same edge, so an aborted write never lands.
  assign commit       = (state == ACCESS) && (cnt == 4'd0) && !rst;

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < 4; i++) begin
      lane_mask[8*i +: 8] = {8{cap_sel[i]}};
    end
  end

  always_ff @(posedge clk) begin
    if (commit && cap_we && !out_of_range) begin
      for (int i = 0; i < 4; i++) begin
        if (cap_sel[i]) begin
          ram[word_idx][8*i +: 8] <= cap_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      cap_adr       <= '0;
      cap_data      <= '0;
      cap_sel       <= '0;
      cap_we        <= 1'b0;
      data_from_mem <= '0;
      mem_busy      <= 1'b0;
      mem_done      <= 1'b0;
      adr_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_done <= 1'b0;
          adr_err  <= 1'b0;
          if (write_to_mem || read_to_mem) begin
            cap_adr  <= adr_to_mem[31:2];
            cap_data <= data_to_mem;
            cap_sel  <= sel_to_mem;
            cap_we   <= write_to_mem;
            cnt      <= 4'(LATENCY);
            mem_busy <= 1'b1;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state    <= IDLE;
            mem_busy <= 1'b0;
            mem_done <= 1'b1;
            adr_err  <= out_of_range;
            if (!cap_we) begin
              data_from_mem <= out_of_range ? 32'd0 : (ram[word_idx] & lane_mask);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: three instances (LATENCY 2, 0, 5) checked every
// cycle against a transaction-level model, plus directed literal checks.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst_a  [3];
  logic        wr     [3];
  logic        rd     [3];
  logic [31:0] adr    [3];
  logic [31:0] wdat   [3];
  logic [3:0]  sel    [3];
  logic [31:0] dout_o [3];
  logic        busy_o [3];
  logic        done_o [3];
  logic        err_o  [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sram_responder #(
      .ADDR_BITS(10),
      .LATENCY  (g == 0 ? 2 : (g == 1 ? 0 : 5))
    ) u_dut (
      .clk          (clk),
      .rst          (rst_a[g]),
      .write_to_mem (wr[g]),
      .read_to_mem  (rd[g]),
      .adr_to_mem   (adr[g]),
      .data_to_mem  (wdat[g]),
      .sel_to_mem   (sel[g]),
      .data_from_mem(dout_o[g]),
      .mem_busy     (busy_o[g]),
      .mem_done     (done_o[g]),
      .adr_err      (err_o[g])
    );
  end

  function automatic int lat(int i);
    return (i == 0) ? 2 : ((i == 1) ? 0 : 5);
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] mram   [3][1024];
  logic [3:0]  mknown [3][1024];
  bit          mvalid [3];
  bit          pend   [3];
  longint      p_end  [3];
  bit          p_we   [3];
  logic [31:0] p_adr  [3];
  logic [31:0] p_dat  [3];
  logic [3:0]  p_sel  [3];
  logic        e_busy [3];
  logic        e_done [3];
  logic        e_err  [3];
  logic [31:0] e_dout [3];
  logic [3:0]  e_kn   [3];
  longint      cyc = 0;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_a[i]) begin
        mvalid[i] = 1'b1;
        pend[i]   = 1'b0;
        e_busy[i] = 1'b0;
        e_done[i] = 1'b0;
        e_err[i]  = 1'b0;
        e_dout[i] = 32'd0;
        e_kn[i]   = 4'hF;
      end else if (pend[i] && cyc == p_end[i]) begin
        bit oor;
        int w;
        oor = (p_adr[i] >= 32'h1000);
        w   = int'((p_adr[i] / 4) % 1024);
        pend[i]   = 1'b0;
        e_busy[i] = 1'b0;
        e_done[i] = 1'b1;
        e_err[i]  = oor;
        if (p_we[i]) begin
          if (!oor) begin
            for (int l = 0; l < 4; l++) begin
              if (p_sel[i][l]) begin
                mram[i][w][8*l +: 8] = p_dat[i][8*l +: 8];
                mknown[i][w][l]      = 1'b1;
              end
            end
          end
        end else begin
          for (int l = 0; l < 4; l++) begin
            if (oor || !p_sel[i][l]) begin
              e_dout[i][8*l +: 8] = 8'd0;
              e_kn[i][l]          = 1'b1;
            end else begin
              e_dout[i][8*l +: 8] = mram[i][w][8*l +: 8];
              e_kn[i][l]          = mknown[i][w][l];
            end
          end
        end
      end else if (pend[i]) begin
        e_busy[i] = 1'b1;
        e_done[i] = 1'b0;
        e_err[i]  = 1'b0;
      end else begin
        e_done[i] = 1'b0;
        e_err[i]  = 1'b0;
        if (wr[i] || rd[i]) begin
          pend[i]   = 1'b1;
          p_end[i]  = cyc + lat(i) + 1;
          p_we[i]   = wr[i];
          p_adr[i]  = adr[i];
          p_dat[i]  = wdat[i];
          p_sel[i]  = sel[i];
          e_busy[i] = 1'b1;
        end else begin
          e_busy[i] = 1'b0;
        end
      end
    end
    cyc++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (mvalid[i]) begin
        logic [31:0] km;
        km = {{8{e_kn[i][3]}}, {8{e_kn[i][2]}}, {8{e_kn[i][1]}}, {8{e_kn[i][0]}}};
        checks++;
        if (busy_o[i] !== e_busy[i]) begin
          failures++;
          $display("FAIL busy inst=%0d cyc=%0d got=%b exp=%b", i, cyc, busy_o[i], e_busy[i]);
        end
        checks++;
        if (done_o[i] !== e_done[i]) begin
          failures++;
          $display("FAIL done inst=%0d cyc=%0d got=%b exp=%b", i, cyc, done_o[i], e_done[i]);
        end
        checks++;
        if (err_o[i] !== e_err[i]) begin
          failures++;
          $display("FAIL adr_err inst=%0d cyc=%0d got=%b exp=%b", i, cyc, err_o[i], e_err[i]);
        end
        checks++;
        if (((dout_o[i] ^ e_dout[i]) & km) !== 32'd0) begin
          failures++;
          $display("FAIL dout inst=%0d cyc=%0d got=%h exp=%h mask=%h", i, cyc, dout_o[i], e_dout[i], km);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic set_req(int i, bit w, bit r, logic [31:0] a, logic [31:0] d, logic [3:0] s);
    wr[i]   = w;
    rd[i]   = r;
    adr[i]  = a;
    wdat[i] = d;
    sel[i]  = s;
  endtask

  task automatic wait_done(int i, output int nbusy, output logic [31:0] d, output logic e);
    bit ok;
    ok    = 1'b0;
    nbusy = 0;
    d     = '0;
    e     = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (done_o[i]) begin
        ok    = 1'b1;
        d     = dout_o[i];
        e     = err_o[i];
        wr[i] = 1'b0;
        rd[i] = 1'b0;
      end else if (busy_o[i]) begin
        nbusy++;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL timeout inst=%0d waiting for mem_done got=0 exp=1", i);
      wr[i] = 1'b0;
      rd[i] = 1'b0;
    end
  endtask

  task automatic txn(int i, bit w, bit r, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                     output int nbusy, output logic [31:0] rdat, output logic e);
    @(negedge clk);
    set_req(i, w, r, a, d, s);
    wait_done(i, nbusy, rdat, e);
  endtask

  function automatic logic [31:0] rand_adr();
    logic [31:0] a;
    if ($urandom_range(0, 7) == 0) begin
      a = (32'h1 << $urandom_range(12, 31)) | ($urandom & 32'hFFF);
    end else begin
      a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    end
    return a;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int          nb;
    logic [31:0] rdat;
    logic        e;
    bit          seen;
    int          last;
    int          pulses;

    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < 1024; w++) begin
        mknown[i][w] = 4'h0;
        mram[i][w]   = 32'h0;
      end
      mvalid[i] = 1'b0;
      pend[i]   = 1'b0;
      rst_a[i]  = 1'b1;
      set_req(i, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    end
    // Reset held two cycles while a write is requested.
    set_req(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_busy", 32'(busy_o[0]), 32'd0);
      chk("rst_done", 32'(done_o[0]), 32'd0);
      chk("rst_dout", dout_o[0], 32'd0);
    end
    for (int i = 0; i < 3; i++) rst_a[i] = 1'b0;
    @(negedge clk);
    chk("first_edge_busy", 32'(busy_o[0]), 32'd1);
    wait_done(0, nb, rdat, e);
    chk("write_busy_rest", 32'(nb), 32'd2);

    txn(0, 1'b0, 1'b1, 32'h10, 32'h0, 4'hF, nb, rdat, e);
    chk("read_busy", 32'(nb), 32'd3);
    chk("read_deadbeef", rdat, 32'hDEADBEEF);

    txn(0, 1'b1, 1'b0, 32'h20, 32'h11223344, 4'hF, nb, rdat, e);
    txn(0, 1'b1, 1'b0, 32'h20, 32'hAABBCCDD, 4'h5, nb, rdat, e);
    txn(0, 1'b0, 1'b1, 32'h20, 32'h0, 4'hF, nb, rdat, e);
    chk("lanes_full", rdat, 32'h11BB33DD);
    txn(0, 1'b0, 1'b1, 32'h20, 32'h0, 4'h3, nb, rdat, e);
    chk("lanes_part", rdat, 32'h000033DD);

    txn(0, 1'b1, 1'b1, 32'h30, 32'h5, 4'hF, nb, rdat, e);
    chk("conflict_dout_held", rdat, 32'h000033DD);
    txn(0, 1'b0, 1'b1, 32'h30, 32'h0, 4'hF, nb, rdat, e);
    chk("conflict_wrote", rdat, 32'h5);

    txn(0, 1'b0, 1'b1, 32'h0000_1000, 32'h0, 4'hF, nb, rdat, e);
    chk("oor_dout", rdat, 32'h0);
    chk("oor_err", 32'(e), 32'd1);
    @(negedge clk);
    chk("oor_err_pulse", 32'(err_o[0]), 32'd0);

    txn(0, 1'b1, 1'b0, 32'h40, 32'h12345678, 4'hF, nb, rdat, e);
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 32'h40, 32'h0000CAFE, 4'hF);
    @(negedge clk);
    @(negedge clk);
    rst_a[0] = 1'b1;
    wr[0]    = 1'b0;
    @(negedge clk);
    rst_a[0] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done_o[0]) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    txn(0, 1'b0, 1'b1, 32'h40, 32'h0, 4'hF, nb, rdat, e);
    chk("abort_prior", rdat, 32'h12345678);

    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 32'h50, 32'h0BADF00D, 4'hF);
    @(negedge clk);
    adr[0]  = 32'h54;
    wdat[0] = 32'h99999999;
    wait_done(0, nb, rdat, e);
    txn(0, 1'b0, 1'b1, 32'h50, 32'h0, 4'hF, nb, rdat, e);
    chk("captured_adr", rdat, 32'h0BADF00D);

    txn(1, 1'b1, 1'b0, 32'h10, 32'hA5A50001, 4'hF, nb, rdat, e);
    chk("lat0_busy", 32'(nb), 32'd1);
    txn(2, 1'b1, 1'b0, 32'h10, 32'hA5A50002, 4'hF, nb, rdat, e);
    chk("lat5_busy", 32'(nb), 32'd6);

    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      set_req(i, 1'b0, 1'b1, 32'h10, 32'h0, 4'hF);
      last   = -1;
      pulses = 0;
      for (int n = 0; n < 60; n++) begin
        @(negedge clk);
        if (done_o[i]) begin
          if (last >= 0) chk($sformatf("held_spacing_%0d", i), 32'(n - last), 32'(lat(i) + 2));
          chk($sformatf("held_data_%0d", i), dout_o[i], (i == 1) ? 32'hA5A50001 : 32'hA5A50002);
          last = n;
          pulses++;
        end
      end
      chk($sformatf("held_pulses_min_%0d", i), 32'(pulses >= 3), 32'd1);
      rd[i] = 1'b0;
      repeat (8) @(negedge clk);
    end

    // Random traffic on all instances, occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        int r;
        r        = $urandom_range(0, 9);
        rst_a[i] = ($urandom_range(0, 199) == 0);
        wr[i]    = (r < 3) || (r == 9);
        rd[i]    = (r >= 3 && r < 6) || (r == 9);
        adr[i]   = rand_adr();
        wdat[i]  = $urandom;
        sel[i]   = 4'($urandom_range(0, 15));
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rst_a[i] = 1'b0;
      set_req(i, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    end
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
